hilo_multiplier: RTL and testbench

- Multi-cycle unsigned 32x32 shift-add multiplier with HI/LO result registers.
- Sits beside the shifter in the ALU datapath. It takes the same dataA/dataB/Signal (funct) bus and drives its dataOut into the same downstream result mux.
- Serves MULTU and, through MFHI/MFLO, places HI or LO on dataOut for the result mux.

---
 rtl/alu_pkg.sv | 18 +
 rtl/hilo_reg.sv | 30 +++
 rtl/hilo_multiplier.sv | 135 +++++++++++++
 tb/tb_hilo_multiplier.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU funct codes, multiplier state encoding and default width
package alu_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [5:0] SRL   = 6'b000010;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/hilo_reg.sv
// rtl/hilo_reg.sv - 2*WIDTH HI/LO result register with write enable
// HI is the upper half of the stored product, LO the lower half.
module hilo_reg #(
  parameter int WIDTH = alu_pkg::DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [2*WIDTH-1:0] wdata,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic [2*WIDTH-1:0] hilo_q;
  logic [2*WIDTH-1:0] hilo_d;

  always_comb begin
    hilo_d = hilo_q;
    if (we) hilo_d = wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) hilo_q <= '0;
    else        hilo_q <= hilo_d;
  end

  assign hi = hilo_q[2*WIDTH-1:WIDTH];
  assign lo = hilo_q[WIDTH-1:0];

endmodule

// File: rtl/hilo_multiplier.sv
// rtl/hilo_multiplier.sv - fixed-latency shift-add multiplier feeding HI/LO for MFHI/MFLO
// Define HILO_MULT_SIGNED_EN to also accept signed MULT (magnitude multiply, sign fixed on write).
module hilo_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mul_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;

  logic               start_u;
  logic               start_s;
  logic               start;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               hilo_we;
  logic [2*WIDTH-1:0] hilo_wdata;
  logic [WIDTH-1:0]   hi, lo;

  assign start_u = (Signal == MULTU);
`ifdef HILO_MULT_SIGNED_EN
  assign start_s = (Signal == MULT);
`else
  assign start_s = 1'b0;
`endif
  assign start = start_u | start_s;

  // Magnitude of 0x80000000 wraps to itself, which read unsigned is exactly 2^31.
  assign a_neg = start_s & dataA[WIDTH-1];
  assign b_neg = start_s & dataB[WIDTH-1];
  assign a_mag = a_neg ? (~dataA + 1'b1) : dataA;
  assign b_mag = b_neg ? (~dataB + 1'b1) : dataB;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    hilo_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          prod_d   = '0;
          cnt_d    = '0;
          neg_d    = a_neg ^ b_neg;
        end
      end
      RUN: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
      end
      DONE: begin
        hilo_we = 1'b1;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign hilo_wdata = neg_q ? (~prod_q + 1'b1) : prod_q;

  hilo_reg #(.WIDTH(WIDTH)) u_hilo_reg (
    .clk   (clk),
    .reset (reset),
    .we    (hilo_we),
    .wdata (hilo_wdata),
    .hi    (hi),
    .lo    (lo)
  );

  always_comb begin
    busy = (state_q == RUN) || (state_q == DONE);
    done = done_q;
    case (Signal)
      MFHI:    dataOut = hi;
      MFLO:    dataOut = lo;
      default: dataOut = '0;
    endcase
  end

endmodule

// File: tb/tb_hilo_multiplier.sv
// tb/tb_hilo_multiplier.sv - directed and random checks of hilo_multiplier against an arithmetic model
module tb_hilo_multiplier;

  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic        clk;
  logic        reset;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  hilo_multiplier dut (
    .clk     (clk),
    .reset   (reset),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues an op for exactly one edge, then parks Signal on a neutral funct.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    Signal = f;
    dataA  = a;
    dataB  = b;
    step();
    Signal = F_SRL;
  endtask

  // Returns edges until done is seen (-1 on timeout) and how many sampled cycles had busy set.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    Signal = F_MFLO;
    #1 lo = dataOut;
    Signal = F_MFHI;
    #1 hi = dataOut;
    Signal = F_SRL;
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (done) pulses++;
    end
  endtask

  task automatic full_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    int          lat, bc, pulses;
    logic [31:0] hi, lo;
    issue(f, a, b);
    wait_done(lat, bc);
    chk({tag, "_latency"}, 64'(lat), 64'd33);
    chk({tag, "_busy_cycles"}, 64'(bc), 64'd33);
    count_done(1, pulses);
    chk({tag, "_done_single"}, 64'(pulses), 64'd0);
    read_hilo(hi, lo);
    chk({tag, "_hi"}, {32'b0, hi}, {32'b0, exp[63:32]});
    chk({tag, "_lo"}, {32'b0, lo}, {32'b0, exp[31:0]});
  endtask

  initial begin
    int          lat, bc, pulses;
    logic [31:0] hi, lo, a, b;
    logic [63:0] exp;

    reset  = 1'b0;
    Signal = F_MFHI;
    dataA  = '0;
    dataB  = '0;
    step();
    step();
    chk("reset_mfhi", {32'b0, dataOut}, 64'd0);
    Signal = F_MFLO;
    #1 chk("reset_mflo", {32'b0, dataOut}, 64'd0);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    reset = 1'b1;
    step();

    full_op("basic_7x6", F_MULTU, 32'd7, 32'd6, 64'd42);
    full_op("full_width", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);

    // Collision: a second MULTU mid-run must not restart or queue.
    issue(F_MULTU, 32'd3, 32'd5);
    for (int k = 1; k < 10; k++) step();
    Signal = F_MULTU;
    dataA  = 32'd9;
    dataB  = 32'd9;
    step();
    Signal = F_MFHI;
    #1 chk("busy_mfhi_prior", {32'b0, dataOut}, 64'hFFFFFFFE);
    Signal = F_MFLO;
    #1 chk("busy_mflo_prior", {32'b0, dataOut}, 64'h00000001);
    Signal = F_SRL;
    dataA  = 32'h12345678;
    dataB  = 32'h9ABCDEF0;
    wait_done(lat, bc);
    chk("collision_latency", 64'(lat), 64'd23);
    count_done(40, pulses);
    chk("collision_no_second_done", 64'(pulses), 64'd0);
    read_hilo(hi, lo);
    chk("collision_lo", {32'b0, lo}, 64'd15);
    chk("collision_hi", {32'b0, hi}, 64'd0);

    // Reset in the middle of a run.
    issue(F_MULTU, 32'h10000, 32'h10000);
    for (int k = 1; k < 20; k++) step();
    reset = 1'b0;
    step();
    chk("midreset_busy", {63'b0, busy}, 64'd0);
    chk("midreset_done", {63'b0, done}, 64'd0);
    reset = 1'b1;
    read_hilo(hi, lo);
    chk("midreset_hi", {32'b0, hi}, 64'd0);
    chk("midreset_lo", {32'b0, lo}, 64'd0);
    count_done(36, pulses);
    chk("midreset_no_done", 64'(pulses), 64'd0);
    full_op("after_reset_2x3", F_MULTU, 32'd2, 32'd3, 64'd6);

    Signal = F_MULTU;
    #1 chk("multu_dataout_zero", {32'b0, dataOut}, 64'd0);
    Signal = F_SRL;
    #1 chk("srl_dataout_zero", {32'b0, dataOut}, 64'd0);

`ifdef HILO_MULT_SIGNED_EN
    full_op("mult_neg3x4", F_MULT, 32'hFFFFFFFD, 32'd4, 64'hFFFFFFFF_FFFFFFF4);
    full_op("mult_min_x_neg1", F_MULT, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    for (int i = 0; i < 4; i++) begin
      a   = $urandom;
      b   = $urandom;
      exp = 64'($signed(64'($signed(a))) * $signed(64'($signed(b))));
      full_op("rand_mult", F_MULT, a, b, exp);
    end
`else
    Signal = F_MULT;
    dataA  = 32'd3;
    dataB  = 32'd4;
    step();
    chk("mult_ignored_busy", {63'b0, busy}, 64'd0);
    chk("mult_ignored_dataout", {32'b0, dataOut}, 64'd0);
    Signal = F_SRL;
    count_done(36, pulses);
    chk("mult_ignored_no_done", 64'(pulses), 64'd0);
    read_hilo(hi, lo);
    chk("mult_ignored_lo", {32'b0, lo}, 64'd6);
`endif

    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i == 0) ? 32'd0 : $urandom;
      exp = 64'(a) * 64'(b);
      full_op("rand_multu", F_MULTU, a, b, exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
